// File: rtl/rr_arb2_pkg.sv
// Shared definitions for the two-source round-robin arbiter stage.
//
// Contents:
//   DATA_W_DEFAULT  default byte-stream width (8)
//   src_e           stream source id; SRC_A=0 / SRC_B=1, same polarity as the mux select
//   other_src()     returns the opposite source, used for round-robin turn taking
package rr_arb2_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/rr_arb2_stage_mux.sv
// Existing 2:1 data mux used as the datapath select of the arbiter stage.
//
// Ports:
//   a_i    in   DATA_W  input selected when sel_i = 0
//   b_i    in   DATA_W  input selected when sel_i = 1
//   sel_i  in   1       select
//   y_o    out  DATA_W  selected data
module rr_arb2_stage_mux
    import rr_arb2_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sel_i,
    output logic [DATA_W-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/rr_arb2_stage.sv
// Two-source valid/ready byte-stream arbiter with a one-entry output register.
// Grants at most one source per cycle, alternating between A and B when both
// are valid, and sustains one beat per clock through the output register.
//
// Ports:
//   clk        in   1       rising-edge clock
//   reset_n    in   1       asynchronous active-low reset
//   a_valid_i  in   1       source A has a beat
//   a_data_i   in   DATA_W  source A data
//   a_ready_o  out  1       A beat accepted this cycle
//   b_valid_i  in   1       source B has a beat
//   b_data_i   in   DATA_W  source B data
//   b_ready_o  out  1       B beat accepted this cycle
//   y_valid_o  out  1       output register holds a beat
//   y_data_o   out  DATA_W  held beat data
//   y_src_o    out  1       origin of held beat (0=A, 1=B)
//   y_ready_i  in   1       downstream takes the held beat
module rr_arb2_stage
    import rr_arb2_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y_data_o,
    output logic              y_src_o,
    input  logic              y_ready_i
);

    src_e              last_grant;
    src_e              grant;
    src_e              y_src_q;
    logic              y_valid_q;
    logic [DATA_W-1:0] y_data_q;
    logic [DATA_W-1:0] mux_y;
    logic              can_load;
    logic              accept;

    // The register may take a new beat when it is empty or is being drained
    // this same cycle, which is what gives back-to-back throughput.
    assign can_load = !y_valid_q || y_ready_i;

    // Grant selection: a lone requester always wins so fairness never blocks
    // single-source traffic; on contention the source that did not win the
    // last accepted beat gets its turn. With no requester the grant value is
    // irrelevant because neither ready can assert.
    always_comb begin
        grant = SRC_A;
        if (a_valid_i && b_valid_i) begin
            grant = other_src(last_grant);
        end else if (b_valid_i) begin
            grant = SRC_B;
        end
    end

    assign a_ready_o = can_load && a_valid_i && (grant == SRC_A);
    assign b_ready_o = can_load && b_valid_i && (grant == SRC_B);
    assign accept    = a_ready_o || b_ready_o;

    rr_arb2_stage_mux #(
        .DATA_W (DATA_W)
    ) u_mux (
        .a_i   (a_data_i),
        .b_i   (b_data_i),
        .sel_i (grant),
        .y_o   (mux_y)
    );

    // Output stage and round-robin memory. last_grant resets to B so the
    // first contention goes to A, and only moves on an actual accept so an
    // unaccepted request cannot steal the other source's turn. On a drain
    // with no new beat, data and source are left as they were.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_valid_q  <= 1'b0;
            y_data_q   <= '0;
            y_src_q    <= SRC_A;
            last_grant <= SRC_B;
        end else if (accept) begin
            y_valid_q  <= 1'b1;
            y_data_q   <= mux_y;
            y_src_q    <= grant;
            last_grant <= grant;
        end else if (y_ready_i) begin
            y_valid_q  <= 1'b0;
        end
    end

    assign y_valid_o = y_valid_q;
    assign y_data_o  = y_data_q;
    assign y_src_o   = y_src_q;

endmodule
